// File: rtl/flash_fetch_pkg.sv
// Shared types and constants for the flash line-fill arbiter.
// Line geometry defaults to a 128-bit line; the top derives its own offset width from LINE_SIZE.
package flash_fetch_pkg;

  localparam int ADDR_W       = 24;
  localparam int LINE_BYTES   = 16;
  localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  function automatic int line_offset_w(input int line_size);
    return $clog2(line_size / 8);
  endfunction

  // Clear the byte-offset bits so equal lines compare equal.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                   input int off_w);
    logic [ADDR_W-1:0] keep;
    keep = '1;
    keep = keep << off_w;
    return addr & keep;
  endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Round-robin selector: first set pend bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
module flash_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [PW-1:0]      rr_ptr,
  output logic [PW-1:0]      g,
  output logic               valid
);

  logic [PW-1:0] idx;

  always_comb begin
    g     = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!valid && pend[idx]) begin
        valid = 1'b1;
        g     = idx;
      end
    end
  end

endmodule

// File: rtl/flash_fetch_arbiter.sv
// Shares one flash line reader between NUM_REQ fill requesters with round-robin grants
// and coalescing of pending fills that target the line already in flight.
module flash_fetch_arbiter
  import flash_fetch_pkg::*;
#(
  parameter int LINE_SIZE = 128,
  parameter int NUM_REQ   = 2
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [LINE_SIZE-1:0]      req_line,
  output logic                      fr_rd,
  output logic [ADDR_W-1:0]         fr_addr,
  input  logic                      fr_done,
  input  logic [LINE_SIZE-1:0]      fr_line,
  output logic                      busy
);

  // Handshake: req_rd, fr_rd, fr_done and req_done are single-cycle strobes with no
  // back-pressure. A requester keeps at most one fill outstanding and waits for its
  // req_done before pulsing req_rd again; the reader answers each fr_rd with one fr_done.

  localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF_W = line_offset_w(LINE_SIZE);

  fetch_state_e       state_q;
  logic [NUM_REQ-1:0] pend_q;
  logic [ADDR_W-1:0]  paddr_q [NUM_REQ];
  logic [PW-1:0]      g_q;
  logic [PW-1:0]      rr_ptr_q;

  logic [PW-1:0]      pick_g;
  logic               pick_valid;
  logic [ADDR_W-1:0]  cur_addr;
  logic [NUM_REQ-1:0] match_mask;
  logic [NUM_REQ-1:0] clear_mask;

  flash_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .pend   (pend_q),
    .rr_ptr (rr_ptr_q),
    .g      (pick_g),
    .valid  (pick_valid)
  );

  assign cur_addr = paddr_q[g_q];
  assign req_line = fr_line;

  // Only bits already pending before fr_done join the in-flight transaction.
  always_comb begin
    match_mask = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      match_mask[j] = pend_q[j] && (paddr_q[j] == cur_addr);
    end
    match_mask[g_q] = 1'b1;
  end

  assign clear_mask = (state_q == ST_WAIT && fr_done) ? match_mask : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= '0;
      for (int j = 0; j < NUM_REQ; j++) begin
        paddr_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (clear_mask[j]) begin
          pend_q[j] <= 1'b0;
        end else if (req_rd[j] && !pend_q[j]) begin
          pend_q[j]  <= 1'b1;
          paddr_q[j] <= align_addr(req_addr[ADDR_W*j +: ADDR_W], OFF_W);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      rr_ptr_q <= PW'(NUM_REQ - 1);
      fr_rd    <= 1'b0;
      fr_addr  <= '0;
      req_done <= '0;
      busy     <= 1'b0;
    end else begin
      req_done <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            g_q     <= pick_g;
            fr_addr <= paddr_q[pick_g];
            fr_rd   <= 1'b1;
            busy    <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          fr_rd   <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fr_done) begin
            req_done <= match_mask;
            rr_ptr_q <= g_q;
            busy     <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          fr_rd   <= 1'b0;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_fetch_arbiter.sv
// Directed bench for flash_fetch_arbiter: the test drives the reader side by hand.
module tb_flash_fetch_arbiter;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [1:0]   req_rd = '0;
  logic [47:0]  req_addr = '0;
  logic [1:0]   req_done;
  logic [127:0] req_line;
  logic         fr_rd;
  logic [23:0]  fr_addr;
  logic         fr_done = 1'b0;
  logic [127:0] fr_line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int rd_count = 0;
  int base;

  flash_fetch_arbiter #(.LINE_SIZE(128), .NUM_REQ(2)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .req_rd   (req_rd),
    .req_addr (req_addr),
    .req_done (req_done),
    .req_line (req_line),
    .fr_rd    (fr_rd),
    .fr_addr  (fr_addr),
    .fr_done  (fr_done),
    .fr_line  (fr_line),
    .busy     (busy)
  );

  // clock / reset block
  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) if (fr_rd) rd_count++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [23:0] a);
    return {8'hA5, a, 8'h3C, ~a, 8'h96, a ^ 24'h5A5A5A, 8'h0F, a + 24'd1};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    HRESETn = 1'b0;
    req_rd  = '0;
    fr_done = 1'b0;
    #1;
    check({tag, "_rst_fr_rd"}, fr_rd, 1'b0);
    check({tag, "_rst_fr_addr"}, fr_addr, 24'h0);
    check({tag, "_rst_req_done"}, req_done, 2'b00);
    check({tag, "_rst_busy"}, busy, 1'b0);
    check({tag, "_rst_line"}, req_line, fr_line);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic drive_req(input logic [1:0] rd, input logic [23:0] a0, input logic [23:0] a1);
    req_rd   = rd;
    req_addr = {a1, a0};
    tick();
    req_rd = '0;
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!fr_rd && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rd_seen"}, fr_rd, 1'b1);
  endtask

  // Serve one transaction: optional late request lands in the fr_done cycle.
  task automatic fill(input string tag, input logic [23:0] exp_addr, input logic [1:0] exp_done,
                      input int lat, input logic [1:0] late_rd, input logic [23:0] late_addr);
    wait_rd(tag);
    check({tag, "_addr"}, fr_addr, exp_addr);
    check({tag, "_busy_issue"}, busy, 1'b1);
    tick();
    check({tag, "_rd_pulse"}, fr_rd, 1'b0);
    repeat (lat) tick();
    check({tag, "_busy_wait"}, busy, 1'b1);
    fr_done = 1'b1;
    fr_line = line_of(exp_addr);
    if (late_rd != 2'b00) begin
      req_rd   = late_rd;
      req_addr = {late_addr, late_addr};
    end
    tick();
    fr_done = 1'b0;
    req_rd  = '0;
    check({tag, "_done"}, req_done, exp_done);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_no_rd_k1"}, fr_rd, 1'b0);
    check({tag, "_line"}, req_line, line_of(exp_addr));
    tick();
    check({tag, "_done_pulse"}, req_done, 2'b00);
  endtask

  initial begin
    do_reset("init");

    // single fill: fr_done at cycle 40, req_done at 41
    drive_req(2'b01, 24'h000124, 24'h0);
    check("single_lat_c1", fr_rd, 1'b0);
    tick();
    check("single_lat_c2", fr_rd, 1'b1);
    fill("single", 24'h000120, 2'b01, 37, 2'b00, 24'h0);

    // fairness: grants 0,1,0,1
    do_reset("fair");
    drive_req(2'b11, 24'h000100, 24'h002000);
    fill("fair0a", 24'h000100, 2'b01, 3, 2'b00, 24'h0);
    fill("fair1a", 24'h002000, 2'b10, 3, 2'b00, 24'h0);
    drive_req(2'b11, 24'h000100, 24'h002000);
    fill("fair0b", 24'h000100, 2'b01, 2, 2'b00, 24'h0);
    fill("fair1b", 24'h002000, 2'b10, 2, 2'b00, 24'h0);

    // coalescing: one transaction serves both
    do_reset("coal");
    base = rd_count;
    req_rd   = 2'b01;
    req_addr = {24'h0, 24'h000104};
    tick();
    req_rd   = 2'b10;
    req_addr = {24'h00010C, 24'h0};
    tick();
    req_rd = '0;
    fill("coal", 24'h000100, 2'b11, 4, 2'b00, 24'h0);
    repeat (4) tick();
    check("coal_rd_count", 32'(rd_count - base), 32'd1);

    // late same-line request in the fr_done cycle gets its own transaction
    do_reset("late");
    base = rd_count;
    drive_req(2'b01, 24'h000100, 24'h0);
    fill("late0", 24'h000100, 2'b01, 3, 2'b10, 24'h000100);
    fill("late1", 24'h000100, 2'b10, 3, 2'b00, 24'h0);
    check("late_rd_count", 32'(rd_count - base), 32'd2);

    // duplicate request while pending is ignored; top-of-space alignment
    do_reset("dup");
    base = rd_count;
    drive_req(2'b01, 24'hFFFFFF, 24'h0);
    drive_req(2'b01, 24'h000400, 24'h0);
    fill("dup", 24'hFFFFF0, 2'b01, 3, 2'b00, 24'h0);
    repeat (4) tick();
    check("dup_rd_count", 32'(rd_count - base), 32'd1);
    check("dup_no_done", req_done, 2'b00);

    // reset during WAIT, then port 0 wins first again
    do_reset("rw");
    drive_req(2'b01, 24'h000500, 24'h0);
    fill("rw_pre", 24'h000500, 2'b01, 2, 2'b00, 24'h0);
    drive_req(2'b10, 24'h0, 24'h000600);
    wait_rd("rw_issue");
    check("rw_issue_addr", fr_addr, 24'h000600);
    tick();
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    check("rw_fr_rd", fr_rd, 1'b0);
    check("rw_fr_addr", fr_addr, 24'h0);
    check("rw_busy", busy, 1'b0);
    check("rw_req_done", req_done, 2'b00);
    tick();
    HRESETn = 1'b1;
    tick();
    drive_req(2'b11, 24'h000700, 24'h000800);
    fill("rw_post0", 24'h000700, 2'b01, 2, 2'b00, 24'h0);
    fill("rw_post1", 24'h000800, 2'b10, 2, 2'b00, 24'h0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
